// File: rtl/bist_pkg.sv
// Shared types and constants for the scan-BIST sequencer.
package bist_pkg;

  localparam int SIG_W = 8;
  localparam logic [SIG_W-1:0] SIGNATURE_VALID_DEFAULT = 8'h27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bist_cycle_counter.sv
// Loadable up-counter with a terminal-count flag; serves as both the
// shift-cycle counter and the pattern counter of the BIST sequencer.
module bist_cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  // load has priority so a clear can never be lost to a simultaneous increment
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (inc) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == terminal);

endmodule

// File: rtl/bist_sequencer.sv
// Scan-based BIST run controller: seeds the LFSR, shifts/captures a fixed
// number of patterns, flushes the chain into the MISR and grades the signature.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int               CHAIN_LEN       = 8,
  parameter int               PATTERN_COUNT   = 16,
  parameter logic [SIG_W-1:0] SIGNATURE_VALID = SIGNATURE_VALID_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bist_start,
  input  logic             bist_abort,
  input  logic [SIG_W-1:0] signature_in,
  output logic             lfsr_load,
  output logic             misr_clear,
  output logic             bist_running,
  output logic             scan_en,
  output logic             bist_end,
  output logic             pass_fail,
  output logic [7:0]       pattern_idx
);

  localparam int                 SHIFT_W      = $clog2(CHAIN_LEN + 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST   = SHIFT_W'(CHAIN_LEN - 1);
  localparam logic [7:0]         PATTERN_LAST = 8'(PATTERN_COUNT - 1);

  state_t state_reg, state_next;
  logic   pass_fail_reg, pass_fail_next;

  logic               shift_load, shift_inc, shift_tc;
  logic [SHIFT_W-1:0] unused_shift_count;
  logic               pattern_load, pattern_inc, pattern_tc;
  logic [7:0]         pattern_count;

  // Shift counter sits at 0 outside SHIFT/UNLOAD, so each entry starts fresh
  assign shift_load   = !(state_reg == ST_SHIFT || state_reg == ST_UNLOAD);
  assign shift_inc    = !shift_load;
  assign pattern_load = (state_next == ST_IDLE) || (state_reg == ST_INIT);
  assign pattern_inc  = (state_reg == ST_CAPTURE);

  bist_cycle_counter #(.WIDTH(SHIFT_W)) u_shift_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (shift_load),
    .load_value ('0),
    .inc        (shift_inc),
    .terminal   (SHIFT_LAST),
    .count      (unused_shift_count),
    .tc         (shift_tc)
  );

  bist_cycle_counter #(.WIDTH(8)) u_pattern_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (pattern_load),
    .load_value (8'd0),
    .inc        (pattern_inc),
    .terminal   (PATTERN_LAST),
    .count      (pattern_count),
    .tc         (pattern_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pass_fail_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pass_fail_reg <= pass_fail_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (bist_start && !bist_abort) state_next = ST_INIT;
      ST_INIT:    state_next = ST_SHIFT;
      ST_SHIFT:   if (shift_tc) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = pattern_tc ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:  if (shift_tc) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_DONE;
      ST_DONE:    if (!bist_start) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (bist_abort && state_reg inside {ST_INIT, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_COMPARE})
      state_next = ST_IDLE;
  end

  // The verdict only lives through DONE; any return to IDLE clears it
  always_comb begin
    pass_fail_next = 1'b0;
    if (state_reg == ST_COMPARE)
      pass_fail_next = (signature_in == SIGNATURE_VALID);
    else if (state_reg == ST_DONE)
      pass_fail_next = pass_fail_reg;
    if (state_next == ST_IDLE)
      pass_fail_next = 1'b0;
  end

  assign lfsr_load    = (state_reg == ST_INIT);
  assign misr_clear   = (state_reg == ST_INIT);
  assign bist_running = state_reg inside {ST_INIT, ST_SHIFT, ST_CAPTURE, ST_UNLOAD, ST_COMPARE};
  assign scan_en      = (state_reg == ST_SHIFT) || (state_reg == ST_UNLOAD);
  assign bist_end     = (state_reg == ST_DONE);
  assign pass_fail    = pass_fail_reg;
  assign pattern_idx  = pattern_count;

endmodule

// File: tb/tb_bist_sequencer.sv
// Randomized scoreboard bench for bist_sequencer: run results are predicted from
// the run timeline and checked by an independent monitor on bist_end.
module tb_bist_sequencer;

  localparam int         C        = 8;
  localparam int         P        = 16;
  localparam logic [7:0] GOLD     = 8'h27;
  localparam int         END_EDGE = 2 + P * (C + 1) + C;

  logic       clock = 1'b0;
  logic       reset, bist_start, bist_abort;
  logic [7:0] signature_in;
  logic       lfsr_load, misr_clear, bist_running, scan_en, bist_end, pass_fail;
  logic [7:0] pattern_idx;
  logic [13:0] outs;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int end_edge;
    int pass;
    int idx;
    int scans;
    int loads;
    int clears;
  } exp_t;
  exp_t exp_q[$];

  logic prev_end;
  int   scans, loads, clears;

  bist_sequencer #(
    .CHAIN_LEN       (C),
    .PATTERN_COUNT   (P),
    .SIGNATURE_VALID (GOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bist_start   (bist_start),
    .bist_abort   (bist_abort),
    .signature_in (signature_in),
    .lfsr_load    (lfsr_load),
    .misr_clear   (misr_clear),
    .bist_running (bist_running),
    .scan_en      (scan_en),
    .bist_end     (bist_end),
    .pass_fail    (pass_fail),
    .pattern_idx  (pattern_idx)
  );

  assign outs = {lfsr_load, misr_clear, bist_running, scan_en, bist_end, pass_fail, pattern_idx};

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_n, act, req);
    end
  endtask

  // Expected outputs r edges after the start edge, from the run timeline:
  // INIT, then P x (C shift + 1 capture), then C unload, then 1 compare.
  function automatic logic [13:0] model_outs(input int r);
    int         ph, u;
    logic       scan;
    logic [7:0] idx;
    if (r == 0) return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    ph = r - 1;
    if (ph < P * (C + 1)) begin
      scan = (ph % (C + 1)) < C;
      idx  = 8'(ph / (C + 1));
    end else begin
      u    = ph - P * (C + 1);
      scan = u < C;
      idx  = 8'(P);
    end
    return {1'b0, 1'b0, 1'b1, scan, 1'b0, 1'b0, idx};
  endfunction

  // Monitor: tallies strobes per run and grades each completed run against the queue
  initial begin
    prev_end = 1'b0;
    scans = 0; loads = 0; clears = 0;
    forever begin
      @(negedge clock);
      if (!bist_running && !bist_end) begin
        scans = 0; loads = 0; clears = 0;
      end else begin
        scans  += int'(scan_en);
        loads  += int'(lfsr_load);
        clears += int'(misr_clear);
      end
      if (bist_end && !prev_end) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("end_edge", edge_n, e.end_edge);
          check("pass_fail", int'(pass_fail), e.pass);
          check("pattern_idx", int'(pattern_idx), e.idx);
          check("scan_cycles", scans, e.scans);
          check("lfsr_load_cycles", loads, e.loads);
          check("misr_clear_cycles", clears, e.clears);
        end
      end
      prev_end = bist_end;
    end
  end

  // One run: start sampled at relative edge 0 and held through edge start_last;
  // abort or reset (if nonzero) sampled at their relative edge.
  task automatic run(input int start_last, input int abort_k, input int rst_k, input logic [7:0] sig);
    int e0, r, kill, stop, done_r;
    e0     = edge_n + 1;
    kill   = (abort_k > 0) ? abort_k : rst_k;
    done_r = (start_last > END_EDGE) ? start_last : END_EDGE;
    stop   = (kill > 0) ? kill + 3 : done_r + 3;
    $display("TXN run e0=%0d start_last=%0d abort_k=%0d rst_k=%0d sig=%02h", e0, start_last, abort_k, rst_k, sig);
    if (kill == 0)
      exp_q.push_back('{e0 + END_EDGE, int'(sig == GOLD), P, P * C + C, 1, 1});
    bist_start   = 1'b1;
    bist_abort   = 1'b0;
    reset        = 1'b0;
    signature_in = 8'($urandom);
    repeat (stop + 1) begin
      @(negedge clock);
      r = edge_n - e0;
      if (r < END_EDGE && (kill == 0 || r < kill))
        check("run_outputs", outs, model_outs(r));
      if (kill > 0 && r == kill)
        check("kill_idle", outs, 0);
      if (kill == 0 && r > END_EDGE && r <= start_last)
        check("held_done", int'(bist_end), 1);
      if (kill == 0 && r == done_r + 1)
        check("post_done_idle", outs, 0);
      bist_start   = (r + 1 <= start_last);
      bist_abort   = (abort_k > 0) && (r + 1 == abort_k);
      reset        = (rst_k > 0) && (r + 1 == rst_k);
      signature_in = (r + 1 == END_EDGE) ? sig : 8'($urandom);
    end
    bist_start = 1'b0;
    bist_abort = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    int kind, sl, k;
    logic [7:0] sig;
    reset        = 1'b1;
    bist_start   = 1'b0;
    bist_abort   = 1'b0;
    signature_in = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_outputs", outs, 0);
    // start and abort together while idle: abort wins, nothing happens
    reset      = 1'b0;
    bist_start = 1'b1;
    bist_abort = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_wins_idle", outs, 0);
    bist_start = 1'b0;
    bist_abort = 1'b0;
    @(negedge clock);

    run(0, 0, 0, GOLD);              // golden signature
    run(0, 0, 0, 8'h26);             // wrong signature
    run(0, 51, 0, GOLD);             // abort mid-shift
    run(0, 0, 46, GOLD);             // reset during capture of pattern 5
    run(0, 0, 0, GOLD);              // fresh full run after reset
    run(END_EDGE + 20, 0, 0, GOLD);  // start held through DONE

    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(0, 3));
      sig  = ($urandom_range(0, 1) == 1) ? GOLD : 8'($urandom);
      k    = int'($urandom_range(1, END_EDGE));
      sl   = int'($urandom_range(0, END_EDGE + 10));
      if (kind == 0)      run(0, k, 0, sig);
      else if (kind == 1) run(0, 0, k, sig);
      else                run(sl, 0, 0, sig);
      repeat (int'($urandom_range(0, 3))) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
